seq_frame_scheduler: RTL and testbench
======================================

# seq_frame_scheduler

Sequencing controller for the serial pattern-detector path. It accepts parallel words over a valid/ready handshake and serializes them MSB-first onto a bit stream, one bit per clock. It runs a programmable Moore-style pattern matcher on that stream, counts hits per frame, and reports a per-frame result with a done pulse. It sits between a word-producing source and the serial detector datapath, and owns the detector's pattern configuration.

## Interface
Parameters:
- WORD_W, 8, bits per frame (≥ PAT_W)
- PAT_W, 4, pattern length in bits
- CNT_W, 4, hit counter width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  pattern write strobe, honoured only in IDLE
- cfg_pattern  in  PAT_W  new pattern, MSB = first bit expected
- in_valid  in  1  source has a word
- in_ready  out  1  block can accept a word
- in_data  in  WORD_W  frame word
- bit_out  out  1  serialized bit (detector d_in)
- match  out  1  registered pattern hit (Moore output)
- hit_count  out  CNT_W  hits in current/last frame
- done  out  1  one-cycle frame-complete pulse
- busy  out  1  frame in progress
- state  out  3  FSM state code for debug

## Operation
- FSM states: IDLE=0, SHIFT=1, REPORT=2. Codes 3–7 are unreachable and recover to IDLE.
- IDLE:
  - in_ready=1, busy=0.
  - cfg_we loads the pattern register.
  - Transfer occurs on in_valid && in_ready at a rising edge. On transfer: capture in_data, clear the bit counter, clear the match history, clear hit_count, go to SHIFT.
  - If cfg_we and a transfer occur on the same edge, the new pattern applies to that frame.
- SHIFT:
  - in_ready=0, busy=1.
  - bit_out = current MSB of the shift register. The register shifts left by one each cycle.
  - The current bit shifts into the PAT_W history.
  - After WORD_W bits, go to REPORT.
  - cfg_we is ignored.
- Matching:
  - A hit occurs when the history, including the bit being shifted, equals the pattern and at least PAT_W bits have been shifted since the last history clear.
  - match is registered and high for exactly the cycle after the completing bit.
  - hit_count increments on the same edge and saturates at 2^CNT_W−1.
  - Matches never span frames.
- REPORT:
  - done=1 for one cycle; busy=1; in_ready=0.
  - The last bit's match is visible in this cycle.
  - Next state is IDLE.
- hit_count holds its value through IDLE until the next transfer.
- Reset values: state=IDLE, in_ready=1 (combinational from state), bit_out=0, match=0, hit_count=0, done=0, busy=0, pattern=4'b1011 truncated/zero-extended to PAT_W.
- Reset mid-frame aborts the frame. No done pulse is produced, and the word is lost.

## Timing
- Transfer edge T0. Bit i (i=1..WORD_W) is on bit_out during cycle T0+i.
- A hit completed by bit i gives match=1 during cycle T0+i+1.
- done is high during cycle T0+WORD_W+1. in_ready rises at T0+WORD_W+2.
- Throughput: one word per WORD_W+2 cycles.
- bit_out is 0 outside SHIFT.

## Configuration
- SEQ_SCHED_OVERLAP_EN defined: the history is kept after a hit, so overlapping matches count.
- SEQ_SCHED_OVERLAP_EN undefined: the history and the PAT_W qualification counter clear on the hit edge, so a new match needs PAT_W fresh bits.

## Structure
- Package seq_sched_pkg:
  - state enum (IDLE/SHIFT/REPORT, 3-bit)
  - default pattern constant 4'b1011
  - bit-counter width function $clog2(WORD_W+1)
- Sub-module seq_pattern_match contains:
  - PAT_W history register
  - qualification counter
  - comparator
  - registered match output
  - clear input
  - overlap-macro logic
- The top level contains the FSM, serializer, handshake and hit counter.

## Test plan
- Reset then idle: all outputs at reset values. in_ready=1. The pattern reads back as 1011 via the first-frame behaviour.
- Default pattern, in_data=8'b1011_0110:
  - bit_out sequence is 1,0,1,1,0,1,1,0.
  - With OVERLAP_EN: match at T0+5 and T0+8; done at T0+9 with hit_count=2.
  - Without OVERLAP_EN: match only at T0+5; hit_count=1.
- Back-to-back frames with in_valid held high: the second transfer occurs at T0+10. hit_count clears at the second transfer, and the second frame 8'h0B gives one hit, at T0+10+9.
- cfg_we with 4'b0110 during SHIFT: ignored, so the current frame still matches 1011. The same write in IDLE takes effect, and 8'b0110_0110 then gives hit_count=2 with overlap enabled.
- Saturation: CNT_W=2, WORD_W=16, pattern 4'b1111, in_data=16'hFFFF with overlap enabled gives hit_count=3, not wrap.
- Reset asserted at T0+4: all outputs return to reset values immediately. No done pulse. in_ready=1 after release.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the frame scheduler and its pattern matcher.
package seq_sched_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      REPORT = 3'd2
   } state_e;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

   // Width of a counter that has to reach word_w itself.
   function automatic int bit_cnt_w(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

// File: rtl/seq_pattern_match.sv
// Moore-style serial pattern matcher: PAT_W-bit history, qualification counter and registered match.
// SEQ_SCHED_OVERLAP_EN keeps the history after a hit; otherwise a hit restarts the qualification.
module seq_pattern_match #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             hit,
   output logic             match
);

   localparam int QW = $clog2(PAT_W + 1);

`ifdef SEQ_SCHED_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   logic [PAT_W-1:0] hist_q, hist_d, hist_next;
   logic [QW-1:0]    qual_q, qual_d;
   logic             match_q, match_d;

   // The qualification counter tracks how many bits the history holds, saturating at PAT_W.
   always_comb begin
      hist_next = {hist_q[PAT_W-2:0], bit_in};
      hit       = shift_en && !clear && (hist_next == pattern) && (qual_q >= QW'(PAT_W - 1));
      hist_d    = hist_q;
      qual_d    = qual_q;
      match_d   = hit;
      if (clear) begin
         hist_d = '0;
         qual_d = '0;
      end else if (shift_en) begin
         if (hit && !OVERLAP) begin
            hist_d = '0;
            qual_d = '0;
         end else begin
            hist_d = hist_next;
            if (qual_q != QW'(PAT_W)) qual_d = qual_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q  <= '0;
         qual_q  <= '0;
         match_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         qual_q  <= qual_d;
         match_q <= match_d;
      end
   end

   assign match = match_q;

endmodule

// File: rtl/seq_frame_scheduler.sv
// Accepts words over valid/ready, serializes them MSB-first, counts pattern hits per frame.
// Overlapping-match counting is selected with SEQ_SCHED_OVERLAP_EN (see seq_pattern_match).
module seq_frame_scheduler
   import seq_sched_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              bit_out,
   output logic              match,
   output logic [CNT_W-1:0]  hit_count,
   output logic              done,
   output logic              busy,
   output logic [2:0]        state
);

   localparam int BCW = bit_cnt_w(WORD_W);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              xfer, shift_en, hit;

   // Handshake: a word moves on any rising edge where in_valid and in_ready are both high;
   // in_ready is high exactly while the FSM sits in IDLE.
   assign in_ready = (state_q == IDLE);
   assign xfer     = in_ready && in_valid;
   assign shift_en = (state_q == SHIFT);
   assign bit_out  = shift_en && sreg_q[WORD_W-1];

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      bcnt_d  = bcnt_q;
      pat_d   = pat_q;
      hcnt_d  = hcnt_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (cfg_we) pat_d = cfg_pattern;
            if (in_valid) begin
               sreg_d  = in_data;
               bcnt_d  = '0;
               hcnt_d  = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d = sreg_q << 1;
            bcnt_d = bcnt_q + 1'b1;
            if (hit && !(&hcnt_q)) hcnt_d = hcnt_q + 1'b1;
            if (bcnt_q == BCW'(WORD_W - 1)) begin
               done_d  = 1'b1;
               state_d = REPORT;
            end
         end
         REPORT: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         bcnt_q  <= '0;
         pat_q   <= PAT_W'(DEFAULT_PATTERN);
         hcnt_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         bcnt_q  <= bcnt_d;
         pat_q   <= pat_d;
         hcnt_q  <= hcnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // The pattern loaded on a transfer edge is already in pat_q for the first shifted bit.
   seq_pattern_match #(
      .PAT_W (PAT_W)
   ) u_match (
      .clk      (clk),
      .rst      (reset),
      .clear    (xfer),
      .shift_en (shift_en),
      .bit_in   (sreg_q[WORD_W-1]),
      .pattern  (pat_q),
      .hit      (hit),
      .match    (match)
   );

   assign hit_count = hcnt_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign state     = state_q;

endmodule

// File: tb/tb_seq_frame_scheduler.sv
// Randomized bench for seq_frame_scheduler against a bit-stream reference model.
`timescale 1ns/1ps
module tb_seq_frame_scheduler;

`ifdef SEQ_SCHED_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   always #5 clk = ~clk;

   logic       cfg_we;
   logic [3:0] cfg_pattern;
   logic       in_valid, in_ready;
   logic [7:0] in_data;
   logic       bit_out, match, done, busy;
   logic [3:0] hit_count;
   logic [2:0] state;

   logic        s_cfg_we;
   logic [3:0]  s_cfg_pattern;
   logic        s_in_valid, s_in_ready;
   logic [15:0] s_in_data;
   logic        s_bit_out, s_match, s_done, s_busy;
   logic [1:0]  s_hit_count;
   logic [2:0]  s_state;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] cur_pat;

   seq_frame_scheduler #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .bit_out(bit_out), .match(match), .hit_count(hit_count),
      .done(done), .busy(busy), .state(state)
   );

   seq_frame_scheduler #(.WORD_W(16), .PAT_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .cfg_we(s_cfg_we), .cfg_pattern(s_cfg_pattern),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .bit_out(s_bit_out), .match(s_match), .hit_count(s_hit_count),
      .done(s_done), .busy(s_busy), .state(s_state)
   );

   // Reference: bit i (1-based) of the stream completes a hit when stream bits i-3..i equal
   // the pattern and, without overlap, at least 4 bits have passed since the previous hit.
   function automatic int model_hits(input logic [15:0] word, input int w,
                                     input logic [3:0] pat, output logic [16:0] hit_at);
      int          n, last;
      logic [15:0] win;
      hit_at = '0;
      n      = 0;
      last   = 0;
      for (int i = 4; i <= w; i++) begin
         win = (word >> (w - i)) & 16'h000F;
         if (win[3:0] == pat && (OVERLAP || (i - last) >= 4)) begin
            hit_at[i] = 1'b1;
            last      = i;
            n++;
         end
      end
      return n;
   endfunction

   // Called right after the transfer edge; checks cycles T0+1 .. T0+9.
   task automatic check_frame_cycles(input logic [7:0] word, input bit hold,
                                     input logic [7:0] next_word, input int cfg_at,
                                     output int final_cnt);
      logic [16:0] h;
      int          cnt, total;
      logic        exp_bit;
      total = model_hits({8'h00, word}, 8, cur_pat, h);
      cnt   = 0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) in_valid = 1'b0;
         cfg_we = (c == cfg_at);
         if (h[c-1]) cnt++;
         exp_bit = (c <= 8) ? word[8-c] : 1'b0;
         checks++; if (bit_out !== exp_bit) begin errors++; $display("FAIL bit_out c=%0d word=%h got %b exp %b", c, word, bit_out, exp_bit); end
         checks++; if (match !== h[c-1]) begin errors++; $display("FAIL match c=%0d word=%h pat=%b got %b exp %b", c, word, cur_pat, match, h[c-1]); end
         checks++; if (done !== (c == 9)) begin errors++; $display("FAIL done c=%0d got %b exp %b", c, done, (c == 9)); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy c=%0d got %b exp 1", c, busy); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_busy c=%0d got %b exp 0", c, in_ready); end
         checks++; if (hit_count !== 4'(cnt)) begin errors++; $display("FAIL hit_count c=%0d word=%h got %0d exp %0d", c, word, hit_count, cnt); end
         checks++; if (state !== ((c == 9) ? 3'd2 : 3'd1)) begin errors++; $display("FAIL state c=%0d got %0d exp %0d", c, state, (c == 9) ? 2 : 1); end
         if (c == 9 && hold) in_data = next_word;
      end
      final_cnt = total;
   endtask

   task automatic check_idle_after_frame(input int exp_cnt);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
      checks++; if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_status got state=%0d busy=%b done=%b exp 0/0/0", state, busy, done); end
      checks++; if (bit_out !== 1'b0 || match !== 1'b0) begin errors++; $display("FAIL idle_outs got bit_out=%b match=%b exp 0/0", bit_out, match); end
      checks++; if (hit_count !== 4'(exp_cnt)) begin errors++; $display("FAIL idle_hold_count got %0d exp %0d", hit_count, exp_cnt); end
   endtask

   task automatic run_frame(input logic [7:0] word, output int cnt);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = word;
      @(posedge clk);
      check_frame_cycles(word, 1'b0, 8'h00, 0, cnt);
      check_idle_after_frame(cnt);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cfg_we = 1'b0; cfg_pattern = 4'h0; in_valid = 1'b0; in_data = 8'h00;
      s_cfg_we = 1'b0; s_cfg_pattern = 4'h0; s_in_valid = 1'b0; s_in_data = 16'h0000;
      cur_pat = 4'b1011;
      repeat (2) @(negedge clk);
      checks++; if ({state, in_ready, bit_out, match, done, busy} !== 8'b000_1_0000) begin errors++; $display("FAIL reset_outs got state=%0d rdy=%b bit=%b m=%b d=%b b=%b", state, in_ready, bit_out, match, done, busy); end
      checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL reset_hit_count got %0d exp 0", hit_count); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%b state=%0d busy=%b", in_ready, state, busy); end
      checks++; if (s_in_ready !== 1'b1 || s_hit_count !== 2'd0) begin errors++; $display("FAIL sat_reset got rdy=%b cnt=%0d", s_in_ready, s_hit_count); end
   endtask

   task automatic test_default_pattern();
      int cnt;
      run_frame(8'b1011_0110, cnt);
      checks++; if (hit_count !== (OVERLAP ? 4'd2 : 4'd1)) begin errors++; $display("FAIL default_frame_count got %0d exp %0d", hit_count, OVERLAP ? 2 : 1); end
   endtask

   task automatic test_back_to_back();
      int cnt1, cnt2;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'b1011_0110;
      @(posedge clk);
      check_frame_cycles(8'b1011_0110, 1'b1, 8'h0B, 0, cnt1);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || hit_count !== 4'(cnt1)) begin errors++; $display("FAIL b2b_gap got rdy=%b cnt=%0d exp 1/%0d", in_ready, hit_count, cnt1); end
      @(posedge clk);
      check_frame_cycles(8'h0B, 1'b0, 8'h00, 0, cnt2);
      check_idle_after_frame(cnt2);
      checks++; if (hit_count !== 4'd1) begin errors++; $display("FAIL b2b_second_count got %0d exp 1", hit_count); end
   endtask

   task automatic test_cfg();
      int cnt;
      cfg_pattern = 4'b0110;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'b1011_0110;
      @(posedge clk);
      check_frame_cycles(8'b1011_0110, 1'b0, 8'h00, 3, cnt);
      check_idle_after_frame(cnt);
      @(negedge clk);
      cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
      cur_pat = 4'b0110;
      run_frame(8'b0110_0110, cnt);
      checks++; if (hit_count !== 4'd2) begin errors++; $display("FAIL cfg_idle_count got %0d exp 2", hit_count); end
      // Pattern write on the transfer edge governs that frame.
      @(negedge clk);
      cfg_we = 1'b1; cfg_pattern = 4'b1011;
      in_valid = 1'b1; in_data = 8'b1011_0000;
      @(posedge clk);
      cur_pat = 4'b1011;
      check_frame_cycles(8'b1011_0000, 1'b0, 8'h00, 0, cnt);
      check_idle_after_frame(cnt);
      checks++; if (hit_count !== 4'd1) begin errors++; $display("FAIL cfg_same_edge_count got %0d exp 1", hit_count); end
   endtask

   task automatic test_random();
      int         cnt;
      logic [7:0] w;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            cfg_pattern = 4'($urandom_range(0, 15));
            cfg_we = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0;
            cur_pat = cfg_pattern;
         end
         case ($urandom_range(0, 2))
            0:       w = {cur_pat, cur_pat};
            1:       w = {2'($urandom_range(0, 3)), cur_pat, 2'($urandom_range(0, 3))};
            default: w = 8'($urandom_range(0, 255));
         endcase
         run_frame(w, cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      int cnt;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'b1011_0110;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if ({state, in_ready, bit_out, match, done, busy} !== 8'b000_1_0000) begin errors++; $display("FAIL midreset_outs got state=%0d rdy=%b bit=%b m=%b d=%b b=%b", state, in_ready, bit_out, match, done, busy); end
      checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", hit_count); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done c=%0d got %b exp 0", c, done); end
      end
      reset = 1'b0;
      cur_pat = 4'b1011;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_midreset c=%0d got done=%b rdy=%b exp 0/1", c, done, in_ready); end
      end
      run_frame(8'b1011_0110, cnt);
      checks++; if (hit_count !== (OVERLAP ? 4'd2 : 4'd1)) begin errors++; $display("FAIL default_after_reset got %0d exp %0d", hit_count, OVERLAP ? 2 : 1); end
   endtask

   task automatic test_saturation();
      logic [16:0] h;
      int          total, cnt, sat;
      total = model_hits(16'hFFFF, 16, 4'b1111, h);
      @(negedge clk);
      s_cfg_pattern = 4'b1111; s_cfg_we = 1'b1;
      @(negedge clk);
      s_cfg_we = 1'b0; s_in_valid = 1'b1; s_in_data = 16'hFFFF;
      @(posedge clk);
      cnt = 0;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         if (c == 1) s_in_valid = 1'b0;
         if (h[c-1]) cnt++;
         sat = (cnt > 3) ? 3 : cnt;
         checks++; if (s_hit_count !== 2'(sat)) begin errors++; $display("FAIL sat_count c=%0d got %0d exp %0d", c, s_hit_count, sat); end
         checks++; if (s_done !== (c == 17)) begin errors++; $display("FAIL sat_done c=%0d got %b exp %b", c, s_done, (c == 17)); end
      end
      checks++; if (s_hit_count !== 2'd3 || total < 4) begin errors++; $display("FAIL sat_final got %0d exp 3 (model hits %0d)", s_hit_count, total); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_default_pattern();
      test_back_to_back();
      test_cfg();
      test_random();
      test_reset_mid_frame();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
